mismatch_check: RTL and testbench
=================================

MISMATCH_CHECK -- requirements
Module: mismatch_check

Interface
REQ-001 SHALL have parameter COEF_WIDTH, default 16, meaning the signed coefficient lane width.
REQ-002 SHALL have parameter DATA_WIDTH, default 64, meaning the stream data width; the number of lanes is MULTIPLE = DATA_WIDTH/COEF_WIDTH.
REQ-003 SHALL have parameter USER_WIDTH, default 2, meaning the t_user width on both stream ports.
REQ-004 SHALL have parameter DEST_WIDTH, default 1, meaning the src t_dest width.
REQ-005 SHALL have parameter CHAIN_ID, default 0, meaning the t_dest value that denotes "routed to this chain".
REQ-006 SHALL have port aclk, input, 1, the only clock; all state changes on its rising edge.
REQ-007 SHALL have port areset, input, 1, reset; asynchronous assert, active-high.
REQ-008 SHALL have port src, nasti_stream_channel.slave, DATA_WIDTH, the coefficient beats from the saturation/mismatch stage.
REQ-009 SHALL have port dst, nasti_stream_channel.master, DATA_WIDTH, the checked coefficient beats.
REQ-010 SHALL have port clr, input, 1, a one-cycle pulse that clears err_status.
REQ-011 SHALL have port err_pulse, output, 4, per-block error flags {strb, range, short, parity}, valid for one cycle.
REQ-012 SHALL have port err_status, output, 4, sticky OR of all err_pulse values since the last reset or clr.

Function
REQ-013 Lane i SHALL be src.t_data[i*COEF_WIDTH +: COEF_WIDTH], signed; legal range [-(2**(E-1)), 2**(E-1)-1] with E = COEF_WIDTH/4*3 (-2048..2047 at default).
REQ-014 SHALL use a single output register stage; src.t_ready = !dst.t_valid || dst.t_ready; a beat accepted in cycle N SHALL appear on dst in cycle N+1.
REQ-015 dst.t_valid SHALL set on acceptance and clear on dst handshake without new acceptance; simultaneous accept and drain SHALL keep it set with the new beat.
REQ-016 dst.t_data and dst.t_last SHALL equal the accepted src.t_data and src.t_last unmodified.
REQ-017 dst.t_user SHALL be {src.t_user[USER_WIDTH-2:0], (src.t_dest == CHAIN_ID)}, reconstructing the routing bit in bit 0.
REQ-018 dst.t_strb and dst.t_keep SHALL be all ones; dst.t_id and dst.t_dest SHALL be 0.
REQ-019 An 8-bit coefficient counter cnt SHALL advance by MULTIPLE per accepted beat; a block SHALL end on the beat where cnt+MULTIPLE == 64 or src.t_last = 1, whichever comes first; cnt then returns to 0.
REQ-020 A parity accumulator SHALL XOR bit 0 of every lane of every beat in the block; the block-end parity includes the ending beat; it resets to 0 at block end.
REQ-021 err_pulse[0] (parity) SHALL assert when block-end parity is 0 (coefficient sum even).
REQ-022 err_pulse[1] (short) SHALL assert when src.t_last ends a block with cnt+MULTIPLE != 64.
REQ-023 err_pulse[2] (range) SHALL assert if any lane of any beat in the block is outside the REQ-013 range; a per-block flag accumulates it.
REQ-024 err_pulse[3] (strb) SHALL assert if any beat in the block has src.t_keep or src.t_strb not all ones; the beat is still forwarded.
REQ-025 err_pulse SHALL be driven in the same cycle the block-ending beat first appears on dst (cycle N+1), and SHALL be 0 in every other cycle.
REQ-026 err_status SHALL OR in err_pulse every cycle; when clr coincides with a nonzero err_pulse, err_status SHALL take that err_pulse value (the new error wins).
REQ-027 dst back-pressure SHALL not lose, duplicate or reorder beats; cnt, parity and the range/strb flags SHALL update only on src handshake.

Reset
REQ-028 While areset = 1: dst.t_valid, dst.t_last, dst.t_user, dst.t_data, err_pulse, err_status, cnt, parity and all per-block flags SHALL be 0.
REQ-029 Assertion of areset mid-block SHALL discard the partial block with no err_pulse; the first beat after release SHALL start a new block at cnt = 0.

Verification
REQ-030 16 beats, lanes {1,0,0,0} on beat 0, zeros elsewhere, t_last on beat 15 -> 16 beats out unchanged, err_pulse = 0.
REQ-031 16 all-zero beats, t_last on beat 15 -> err_pulse = 4'b0001 in the cycle beat 15 appears; err_status = 4'b0001 afterwards.
REQ-032 Beat 0 lane 2 = 16'h0800 (2048), odd sum, 16 beats -> err_pulse = 4'b0100; a following clr -> err_status = 0.
REQ-033 t_last on beat 3 with odd sum -> err_pulse = 4'b0010; the next beat restarts at cnt = 0.
REQ-034 src.t_dest = CHAIN_ID, t_user = 2'b01 -> dst.t_user = 2'b11; t_dest != CHAIN_ID -> dst.t_user = 2'b10.
REQ-035 Random dst.t_ready at 50% over 3 blocks -> output matches input beat-for-beat; err_pulse fires exactly once per erroneous block.

Source files
------------

// File: rtl/mismatch_check_if.sv
// AXI4-Stream style channel used between the coefficient pipeline stages.
//   master : drives t_valid/t_data/t_strb/t_keep/t_last/t_id/t_dest/t_user, samples t_ready
//   slave  : samples the payload, drives t_ready
interface nasti_stream_channel #(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned USER_WIDTH = 2,
  parameter int unsigned DEST_WIDTH = 1,
  parameter int unsigned ID_WIDTH   = 1
);
  logic                    t_valid;
  logic                    t_ready;
  logic [DATA_WIDTH-1:0]   t_data;
  logic [DATA_WIDTH/8-1:0] t_strb;
  logic [DATA_WIDTH/8-1:0] t_keep;
  logic                    t_last;
  logic [ID_WIDTH-1:0]     t_id;
  logic [DEST_WIDTH-1:0]   t_dest;
  logic [USER_WIDTH-1:0]   t_user;

  modport master (
    output t_valid, t_data, t_strb, t_keep, t_last, t_id, t_dest, t_user,
    input  t_ready
  );

  modport slave (
    input  t_valid, t_data, t_strb, t_keep, t_last, t_id, t_dest, t_user,
    output t_ready
  );
endinterface

// File: rtl/mismatch_check.sv
// Coefficient block checker. Forwards each src beat through one register stage and checks
// every 64-coefficient block (or shorter block ended by t_last) for even parity, short length,
// out-of-range lanes and partial strobes.
//   aclk, areset : clock, asynchronous active-high reset
//   src          : coefficient beats in (slave)
//   dst          : checked beats out (master), t_user bit 0 carries the routing bit
//   clr          : one-cycle pulse clearing err_status
//   err_pulse    : {strb, range, short, parity}, one cycle alongside the block-ending beat
//   err_status   : sticky OR of err_pulse
module mismatch_check #(
  parameter int unsigned COEF_WIDTH = 16,
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned USER_WIDTH = 2,
  parameter int unsigned DEST_WIDTH = 1,
  parameter int unsigned CHAIN_ID   = 0
) (
  input  logic                aclk,
  input  logic                areset,
  nasti_stream_channel.slave  src,
  nasti_stream_channel.master dst,
  input  logic                clr,
  output logic [3:0]          err_pulse,
  output logic [3:0]          err_status
);

  localparam int unsigned MULTIPLE  = DATA_WIDTH / COEF_WIDTH;
  localparam int unsigned EXP_WIDTH = COEF_WIDTH / 4 * 3;
  // Bits [COEF_WIDTH-1:EXP_WIDTH-1] must be a pure sign extension for a lane to be in range.
  localparam int unsigned TOP_BITS  = COEF_WIDTH - EXP_WIDTH + 1;

  logic                  valid_q, valid_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  last_q, last_d;
  logic [USER_WIDTH-1:0] user_q, user_d;
  logic [7:0]            cnt_q, cnt_d;
  logic                  par_q, par_d;
  logic                  range_q, range_d;
  logic                  strb_q, strb_d;
  logic [3:0]            err_pulse_q, err_pulse_d;
  logic [3:0]            err_status_q, err_status_d;

  logic                  accept;
  logic [7:0]            cnt_sum;
  logic                  block_full;
  logic                  block_end;
  logic                  beat_par;
  logic                  beat_range_bad;
  logic                  beat_strb_bad;
  logic                  par_tot, range_tot, strb_tot;
  logic                  unused_src;

  assign src.t_ready = !valid_q || dst.t_ready;
  assign accept      = src.t_valid && src.t_ready;

  assign cnt_sum    = cnt_q + 8'(MULTIPLE);
  assign block_full = (cnt_sum == 8'd64);
  assign block_end  = accept && (block_full || src.t_last);

  always_comb begin
    logic [COEF_WIDTH-1:0] lane;
    logic [TOP_BITS-1:0]   top;
    beat_par       = 1'b0;
    beat_range_bad = 1'b0;
    lane           = '0;
    top            = '0;
    for (int i = 0; i < int'(MULTIPLE); i++) begin
      lane     = src.t_data[i*COEF_WIDTH +: COEF_WIDTH];
      top      = lane[COEF_WIDTH-1:EXP_WIDTH-1];
      beat_par = beat_par ^ lane[0];
      if (!((top == '0) || (top == '1))) beat_range_bad = 1'b1;
    end
  end

  assign beat_strb_bad = !((&src.t_keep) && (&src.t_strb));
  assign par_tot       = par_q ^ beat_par;
  assign range_tot     = range_q | beat_range_bad;
  assign strb_tot      = strb_q | beat_strb_bad;

  always_comb begin
    valid_d      = valid_q;
    data_d       = data_q;
    last_d       = last_q;
    user_d       = user_q;
    cnt_d        = cnt_q;
    par_d        = par_q;
    range_d      = range_q;
    strb_d       = strb_q;
    err_pulse_d  = '0;

    if (accept) begin
      valid_d = 1'b1;
      data_d  = src.t_data;
      last_d  = src.t_last;
      user_d  = {src.t_user[USER_WIDTH-2:0], (src.t_dest == DEST_WIDTH'(CHAIN_ID))};
      if (block_end) begin
        cnt_d       = '0;
        par_d       = 1'b0;
        range_d     = 1'b0;
        strb_d      = 1'b0;
        err_pulse_d = {strb_tot, range_tot, (src.t_last && !block_full), !par_tot};
      end else begin
        cnt_d   = cnt_sum;
        par_d   = par_tot;
        range_d = range_tot;
        strb_d  = strb_tot;
      end
    end else if (dst.t_ready) begin
      valid_d = 1'b0;
    end

    // A coincident clear loses to a fresh error so that error is never dropped.
    err_status_d = clr ? err_pulse_q : (err_status_q | err_pulse_q);
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      valid_q      <= 1'b0;
      data_q       <= '0;
      last_q       <= 1'b0;
      user_q       <= '0;
      cnt_q        <= '0;
      par_q        <= 1'b0;
      range_q      <= 1'b0;
      strb_q       <= 1'b0;
      err_pulse_q  <= '0;
      err_status_q <= '0;
    end else begin
      valid_q      <= valid_d;
      data_q       <= data_d;
      last_q       <= last_d;
      user_q       <= user_d;
      cnt_q        <= cnt_d;
      par_q        <= par_d;
      range_q      <= range_d;
      strb_q       <= strb_d;
      err_pulse_q  <= err_pulse_d;
      err_status_q <= err_status_d;
    end
  end

  assign dst.t_valid = valid_q;
  assign dst.t_data  = data_q;
  assign dst.t_last  = last_q;
  assign dst.t_user  = user_q;
  assign dst.t_strb  = '1;
  assign dst.t_keep  = '1;
  assign dst.t_id    = '0;
  assign dst.t_dest  = '0;

  assign err_pulse  = err_pulse_q;
  assign err_status = err_status_q;

  assign unused_src = ^{src.t_id, src.t_user[USER_WIDTH-1]};

endmodule

// File: tb/tb_mismatch_check.sv
module tb_mismatch_check;

  typedef struct packed {
    logic [63:0] data;
    logic        last;
    logic [1:0]  user;
  } beat_t;

  logic       aclk = 1'b0;
  logic       areset = 1'b1;
  logic       clr = 1'b0;
  logic [3:0] err_pulse;
  logic [3:0] err_status;
  logic       rand_ready = 1'b0;

  int n_cmp = 0;
  int n_fail = 0;

  beat_t      exp_q[$];
  beat_t      out_q[$];
  logic [3:0] pulse_q[$];
  logic       pulse_last_q[$];

  nasti_stream_channel #(.DATA_WIDTH(64), .USER_WIDTH(2), .DEST_WIDTH(1)) src_if ();
  nasti_stream_channel #(.DATA_WIDTH(64), .USER_WIDTH(2), .DEST_WIDTH(1)) dst_if ();

  mismatch_check #(
    .COEF_WIDTH(16), .DATA_WIDTH(64), .USER_WIDTH(2), .DEST_WIDTH(1), .CHAIN_ID(0)
  ) dut (
    .aclk       (aclk),
    .areset     (areset),
    .src        (src_if),
    .dst        (dst_if),
    .clr        (clr),
    .err_pulse  (err_pulse),
    .err_status (err_status)
  );

  initial forever #5 aclk = ~aclk;

  // Sink ready changes only on negedges; everything is sampled 1 time unit before posedge.
  initial begin
    dst_if.t_ready = 1'b1;
    forever begin
      @(negedge aclk);
      dst_if.t_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  initial forever begin
    @(negedge aclk);
    #4;
    if (!areset) begin
      if (dst_if.t_valid && dst_if.t_ready)
        out_q.push_back(beat_t'{data: dst_if.t_data, last: dst_if.t_last, user: dst_if.t_user});
      if (err_pulse != 4'b0) begin
        pulse_q.push_back(err_pulse);
        pulse_last_q.push_back(dst_if.t_valid && dst_if.t_last);
      end
    end
  end

  function automatic logic [63:0] lanes(input logic [15:0] l3, l2, l1, l0);
    return {l3, l2, l1, l0};
  endfunction

  task automatic clear_q();
    exp_q.delete(); out_q.delete(); pulse_q.delete(); pulse_last_q.delete();
  endtask

  task automatic send_beat(input logic [63:0] d, input logic last, input logic [1:0] user,
                           input logic dest, input logic [7:0] keep);
    int guard = 0;
    @(negedge aclk);
    src_if.t_valid = 1'b1;
    src_if.t_data  = d;
    src_if.t_last  = last;
    src_if.t_user  = user;
    src_if.t_dest  = dest;
    src_if.t_keep  = keep;
    src_if.t_strb  = 8'hff;
    exp_q.push_back(beat_t'{data: d, last: last, user: {user[0], dest == 1'b0}});
    #1;
    while (!src_if.t_ready && guard < 200) begin
      @(negedge aclk);
      #1;
      guard++;
    end
    if (guard >= 200) begin
      n_cmp++; n_fail++;
      $display("FAIL send_timeout: src.t_ready stuck at %b, required 1", src_if.t_ready);
    end
    @(posedge aclk);
  endtask

  task automatic src_idle();
    @(negedge aclk);
    src_if.t_valid = 1'b0;
    src_if.t_last  = 1'b0;
  endtask

  task automatic drain();
    int g = 0;
    src_idle();
    while (dst_if.t_valid && g < 200) begin
      @(negedge aclk);
      g++;
    end
    if (g >= 200) begin
      n_cmp++; n_fail++;
      $display("FAIL drain_timeout: dst.t_valid still %b, required 0", dst_if.t_valid);
    end
    repeat (3) @(negedge aclk);
    #4;
  endtask

  task automatic pulse_clr();
    @(negedge aclk);
    clr = 1'b1;
    @(negedge aclk);
    clr = 1'b0;
    #1;
  endtask

  // 16-beat block; beat0 lane0 set to `odd`, optional extra lanes on beat `xb`.
  task automatic send_block(input logic odd, input int xb, input logic [63:0] xd,
                            input logic [7:0] xkeep);
    logic [63:0] d;
    for (int b = 0; b < 16; b++) begin
      d = (b == 0) ? lanes(16'h0, 16'h0, 16'h0, {15'h0, odd}) : 64'h0;
      if (b == xb) d = d | xd;
      send_beat(d, b == 15, 2'b00, 1'b0, (b == xb) ? xkeep : 8'hff);
    end
  endtask

  task automatic test_reset();
    src_if.t_valid = 1'b0; src_if.t_data = '0; src_if.t_last = 1'b0; src_if.t_user = '0;
    src_if.t_dest = '0; src_if.t_keep = '1; src_if.t_strb = '1; src_if.t_id = '0;
    areset = 1'b1;
    repeat (2) @(negedge aclk);
    #4;
    n_cmp++; if (dst_if.t_valid !== 1'b0) begin
      n_fail++; $display("FAIL reset_valid: got %b want 0", dst_if.t_valid); end
    n_cmp++; if (dst_if.t_data !== 64'h0) begin
      n_fail++; $display("FAIL reset_data: got %h want 0", dst_if.t_data); end
    n_cmp++; if (err_pulse !== 4'b0) begin
      n_fail++; $display("FAIL reset_pulse: got %b want 0000", err_pulse); end
    n_cmp++; if (err_status !== 4'b0) begin
      n_fail++; $display("FAIL reset_status: got %b want 0000", err_status); end
    n_cmp++; if (src_if.t_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_ready: got %b want 1", src_if.t_ready); end
    @(negedge aclk);
    areset = 1'b0;
  endtask

  task automatic test_pass();
    clear_q();
    send_block(1'b1, -1, 64'h0, 8'hff);
    drain();
    n_cmp++; if (out_q.size() !== 16) begin
      n_fail++; $display("FAIL pass_count: got %0d want 16", out_q.size()); end
    for (int i = 0; i < out_q.size() && i < exp_q.size(); i++) begin
      n_cmp++; if (out_q[i] !== exp_q[i]) begin
        n_fail++; $display("FAIL pass_beat%0d: got %h want %h", i, out_q[i], exp_q[i]); end
    end
    n_cmp++; if (pulse_q.size() !== 0) begin
      n_fail++; $display("FAIL pass_pulse: got %0d pulses want 0", pulse_q.size()); end
    n_cmp++; if (err_status !== 4'b0) begin
      n_fail++; $display("FAIL pass_status: got %b want 0000", err_status); end
  endtask

  task automatic test_parity();
    clear_q();
    send_block(1'b0, -1, 64'h0, 8'hff);
    drain();
    n_cmp++; if (pulse_q.size() !== 1 || pulse_q[0] !== 4'b0001) begin
      n_fail++; $display("FAIL parity_pulse: got %0d pulses first %b want 1 x 0001",
                         pulse_q.size(), (pulse_q.size() > 0) ? pulse_q[0] : 4'b0); end
    n_cmp++; if (pulse_last_q.size() !== 1 || pulse_last_q[0] !== 1'b1) begin
      n_fail++; $display("FAIL parity_timing: pulse not with last beat, want with last beat"); end
    n_cmp++; if (err_status !== 4'b0001) begin
      n_fail++; $display("FAIL parity_status: got %b want 0001", err_status); end
    pulse_clr();
    n_cmp++; if (err_status !== 4'b0) begin
      n_fail++; $display("FAIL parity_clr: got %b want 0000", err_status); end
  endtask

  task automatic test_range_clr();
    clear_q();
    // 2048 on lane 2 is one past the top of the range.
    send_block(1'b1, 0, lanes(16'h0, 16'h0800, 16'h0, 16'h0), 8'hff);
    drain();
    n_cmp++; if (pulse_q.size() !== 1 || pulse_q[0] !== 4'b0100) begin
      n_fail++; $display("FAIL range_pulse: got %0d pulses first %b want 1 x 0100",
                         pulse_q.size(), (pulse_q.size() > 0) ? pulse_q[0] : 4'b0); end
    n_cmp++; if (err_status !== 4'b0100) begin
      n_fail++; $display("FAIL range_status: got %b want 0100", err_status); end
    pulse_clr();
    n_cmp++; if (err_status !== 4'b0) begin
      n_fail++; $display("FAIL range_clr: got %b want 0000", err_status); end
    // Exact edges 2047 and -2048 are legal; lane0 bit makes the sum even, 07FF makes it odd.
    clear_q();
    send_block(1'b0, 3, lanes(16'h07ff, 16'hf800, 16'h0, 16'h0), 8'hff);
    drain();
    n_cmp++; if (pulse_q.size() !== 0) begin
      n_fail++; $display("FAIL range_edges: got %0d pulses want 0", pulse_q.size()); end
    clear_q();
    send_block(1'b1, 7, lanes(16'h0, 16'h0, 16'hf7fe, 16'h0), 8'hff);
    drain();
    n_cmp++; if (pulse_q.size() !== 1 || pulse_q[0] !== 4'b0100) begin
      n_fail++; $display("FAIL range_neg: got %0d pulses first %b want 1 x 0100",
                         pulse_q.size(), (pulse_q.size() > 0) ? pulse_q[0] : 4'b0); end
    pulse_clr();
  endtask

  task automatic test_strb();
    clear_q();
    send_block(1'b1, 9, 64'h0, 8'hfe);
    drain();
    n_cmp++; if (out_q.size() !== 16) begin
      n_fail++; $display("FAIL strb_forward: got %0d beats want 16", out_q.size()); end
    n_cmp++; if (pulse_q.size() !== 1 || pulse_q[0] !== 4'b1000) begin
      n_fail++; $display("FAIL strb_pulse: got %0d pulses first %b want 1 x 1000",
                         pulse_q.size(), (pulse_q.size() > 0) ? pulse_q[0] : 4'b0); end
    pulse_clr();
  endtask

  task automatic test_short();
    clear_q();
    for (int b = 0; b < 4; b++)
      send_beat((b == 0) ? 64'h1 : 64'h0, b == 3, 2'b00, 1'b0, 8'hff);
    send_block(1'b1, -1, 64'h0, 8'hff);
    drain();
    n_cmp++; if (pulse_q.size() !== 1 || pulse_q[0] !== 4'b0010) begin
      n_fail++; $display("FAIL short_pulse: got %0d pulses first %b want 1 x 0010",
                         pulse_q.size(), (pulse_q.size() > 0) ? pulse_q[0] : 4'b0); end
    n_cmp++; if (err_status !== 4'b0010) begin
      n_fail++; $display("FAIL short_status: got %b want 0010", err_status); end
    pulse_clr();
  endtask

  task automatic test_reset_mid_block();
    clear_q();
    send_beat(64'h1, 1'b0, 2'b01, 1'b0, 8'hff);
    send_beat(64'h0, 1'b0, 2'b01, 1'b1, 8'hff);
    send_beat(64'h0, 1'b0, 2'b10, 1'b0, 8'hff);
    drain();
    n_cmp++; if (out_q.size() !== 3) begin
      n_fail++; $display("FAIL user_count: got %0d want 3", out_q.size()); end
    else begin
      n_cmp++; if (out_q[0].user !== 2'b11) begin
        n_fail++; $display("FAIL user_match: got %b want 11", out_q[0].user); end
      n_cmp++; if (out_q[1].user !== 2'b10) begin
        n_fail++; $display("FAIL user_nomatch: got %b want 10", out_q[1].user); end
      n_cmp++; if (out_q[2].user !== 2'b01) begin
        n_fail++; $display("FAIL user_shift: got %b want 01", out_q[2].user); end
    end
    @(negedge aclk);
    areset = 1'b1;
    repeat (2) @(negedge aclk);
    areset = 1'b0;
    clear_q();
    send_block(1'b1, -1, 64'h0, 8'hff);
    drain();
    n_cmp++; if (pulse_q.size() !== 0) begin
      n_fail++; $display("FAIL midreset_restart: got %0d pulses want 0", pulse_q.size()); end
    n_cmp++; if (err_status !== 4'b0) begin
      n_fail++; $display("FAIL midreset_status: got %b want 0000", err_status); end
  endtask

  task automatic test_back_to_back();
    logic [63:0] d;
    clear_q();
    rand_ready = 1'b1;
    for (int blk = 0; blk < 3; blk++) begin
      for (int b = 0; b < 16; b++) begin
        // Distinct even lanes so reordering shows; parity/range set per block below.
        d = lanes(16'((blk*64 + b*4 + 3) * 2), 16'((blk*64 + b*4 + 2) * 2),
                  16'((blk*64 + b*4 + 1) * 2), 16'((blk*64 + b*4) * 2));
        if (b == 0 && blk != 1) d[0] = 1'b1;
        if (blk == 2 && b == 5) d[63:48] = 16'h1000;
        send_beat(d, b == 15, 2'b00, 1'b0, 8'hff);
      end
    end
    src_idle();
    repeat (10) @(negedge aclk);
    rand_ready = 1'b0;
    drain();
    n_cmp++; if (out_q.size() !== 48) begin
      n_fail++; $display("FAIL bp_count: got %0d want 48", out_q.size()); end
    for (int i = 0; i < out_q.size() && i < exp_q.size(); i++) begin
      n_cmp++; if (out_q[i] !== exp_q[i]) begin
        n_fail++; $display("FAIL bp_beat%0d: got %h want %h", i, out_q[i], exp_q[i]); end
    end
    n_cmp++; if (pulse_q.size() !== 2) begin
      n_fail++; $display("FAIL bp_pulses: got %0d want 2", pulse_q.size()); end
    else begin
      n_cmp++; if (pulse_q[0] !== 4'b0001 || pulse_q[1] !== 4'b0100) begin
        n_fail++; $display("FAIL bp_pulse_vals: got %b,%b want 0001,0100",
                           pulse_q[0], pulse_q[1]); end
    end
  endtask

  initial begin
    test_reset();
    test_pass();
    test_parity();
    test_range_clr();
    test_strb();
    test_short();
    test_reset_mid_block();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
